// File: rtl/seg7_to_hex.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_to_hex
//  Description : Decodes active-low 7-segment patterns into hex digits and
//                assembles NIBBLES of them, first digit in the MSB, into a word.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_to_hex #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [6:0]             seg_in,
    input  logic                   seg_valid,
    output logic                   seg_ready,
    output logic [4*NIBBLES-1:0]   word,
    output logic                   word_valid,
    input  logic                   word_ready,
    output logic                   err,
    output logic [7:0]             err_cnt
);

    localparam int               c_CNT_W   = $clog2(NIBBLES + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(NIBBLES - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_COLLECT = 2'd1;
    localparam logic [1:0] c_HOLD    = 2'd2;

    logic [1:0]            r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [4*NIBBLES-1:0]  r_word;
    logic                  r_err;
    logic [7:0]            r_err_cnt;

    logic [3:0]            w_nib;
    logic                  w_legal;
    logic                  w_accept;
    logic [4*NIBBLES-1:0]  w_shifted;

    always_comb begin
        w_nib   = 4'h0;
        w_legal = 1'b1;
        case (seg_in)
            7'h40: w_nib = 4'h0;
            7'h79: w_nib = 4'h1;
            7'h24: w_nib = 4'h2;
            7'h30: w_nib = 4'h3;
            7'h19: w_nib = 4'h4;
            7'h12: w_nib = 4'h5;
            7'h02: w_nib = 4'h6;
            7'h78: w_nib = 4'h7;
            7'h00: w_nib = 4'h8;
            7'h10: w_nib = 4'h9;
            7'h08: w_nib = 4'hA;
            7'h03: w_nib = 4'hB;
            7'h46: w_nib = 4'hC;
            7'h21: w_nib = 4'hD;
            7'h06: w_nib = 4'hE;
            7'h0E: w_nib = 4'hF;
            default: w_legal = 1'b0;
        endcase
    end

    // A single-digit word has nothing to shift out, so it is replaced outright.
    generate
        if (NIBBLES == 1) begin : g_single
            assign w_shifted = w_nib;
        end else begin : g_multi
            assign w_shifted = {r_word[4*NIBBLES-5:0], w_nib};
        end
    endgenerate

    assign seg_ready  = (r_state != c_HOLD);
    assign w_accept   = seg_valid && seg_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_word    <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= 8'd0;
        end else begin
            r_err <= 1'b0;
            if (r_state == c_HOLD) begin
                if (word_ready) begin
                    r_state <= c_IDLE;
                    r_cnt   <= '0;
                end
            end else if (w_accept) begin
                if (w_legal) begin
                    r_word <= w_shifted;
                    r_cnt  <= r_cnt + c_ONE;
                    r_state <= (r_cnt == c_LAST) ? c_HOLD : c_COLLECT;
                end else begin
                    // Bad pattern: drop the partial word but leave r_word as is.
                    r_state <= c_IDLE;
                    r_cnt   <= '0;
                    r_err   <= 1'b1;
                    if (r_err_cnt != 8'hFF) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                end
            end
        end
    end

    assign word       = r_word;
    assign word_valid = (r_state == c_HOLD);
    assign err        = r_err;
    assign err_cnt    = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seg7_to_hex.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_to_hex
//  Description : Directed and random stimulus for seg7_to_hex (NIBBLES=4)
//                checked every cycle against a digit-queue reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_to_hex;

    logic        clk = 1'b0;
    logic        resetn;
    logic [6:0]  seg_in;
    logic        seg_valid;
    logic        seg_ready;
    logic [15:0] word;
    logic        word_valid;
    logic        word_ready;
    logic        err;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    seg7_to_hex #(.NIBBLES(4)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .seg_in     (seg_in),
        .seg_valid  (seg_valid),
        .seg_ready  (seg_ready),
        .word       (word),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .err        (err),
        .err_cnt    (err_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Segment pattern for digit value i is tbl[i].
    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int          held[$];
    bit          m_hold;
    int          m_word;
    bit          m_err;
    int          m_cnt;

    function automatic int lookup(input logic [6:0] p);
        for (int i = 0; i < 16; i++) begin
            if (tbl[i] == p) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":seg_ready"},  32'(seg_ready),  32'(!m_hold));
        chk({tag, ":word_valid"}, 32'(word_valid), 32'(m_hold));
        chk({tag, ":word"},       32'(word),       32'(m_word));
        chk({tag, ":err"},        32'(err),        32'(m_err));
        chk({tag, ":err_cnt"},    32'(err_cnt),    32'(m_cnt));
    endtask

    task automatic model_reset();
        held.delete();
        m_hold = 1'b0;
        m_word = 0;
        m_err  = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic model_edge();
        int d;
        m_err = 1'b0;
        if (m_hold) begin
            if (word_ready) begin
                m_hold = 1'b0;
                held.delete();
            end
        end else if (seg_valid) begin
            d = lookup(seg_in);
            if (d < 0) begin
                held.delete();
                m_err = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end else begin
                held.push_back(d);
                m_word = (m_word * 16 + d) % 65536;
                if (held.size() == 4) m_hold = 1'b1;
            end
        end
    endtask

    task automatic cyc(input string tag, input bit sv, input logic [6:0] sin, input bit wr);
        seg_valid  = sv;
        seg_in     = sin;
        word_ready = wr;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic send4(input string tag, input logic [6:0] p0, input logic [6:0] p1,
                         input logic [6:0] p2, input logic [6:0] p3, input bit wr);
        cyc(tag, 1'b1, p0, wr);
        cyc(tag, 1'b1, p1, wr);
        cyc(tag, 1'b1, p2, wr);
        cyc(tag, 1'b1, p3, wr);
    endtask

    // Called at posedge+1: asserts reset mid-cycle and checks before any edge.
    task automatic pulse_reset(input string tag);
        #3;
        resetn = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        logic [6:0] pat;
        resetn     = 1'b1;
        seg_valid  = 1'b0;
        seg_in     = 7'h7F;
        word_ready = 1'b0;
        model_reset();
        #2;
        resetn = 1'b0;
        #1;
        check_all("reset");
        @(posedge clk);
        #1;
        check_all("reset_held");
        resetn = 1'b1;

        // 1234 back to back, word visible for one cycle only
        send4("w1234", 7'h79, 7'h24, 7'h30, 7'h19, 1'b1);
        chk("w1234_value", 32'(word), 32'h1234);
        chk("w1234_valid", 32'(word_valid), 32'h1);
        cyc("w1234_drop", 1'b0, 7'h7F, 1'b1);

        // all sixteen table patterns
        for (int w = 0; w < 4; w++) begin
            send4("table", tbl[4*w], tbl[4*w+1], tbl[4*w+2], tbl[4*w+3], 1'b0);
            chk("table_word", 32'(word), 32'(16'h0123 + w * 16'h4444));
            cyc("table_pop", 1'b0, 7'h7F, 1'b1);
        end

        // invalid mid-word, then 8888
        cyc("inv", 1'b1, 7'h40, 1'b0);
        cyc("inv", 1'b1, 7'h40, 1'b0);
        cyc("inv", 1'b1, 7'h7F, 1'b0);
        chk("inv_err", 32'(err), 32'h1);
        chk("inv_cnt", 32'(err_cnt), 32'h1);
        send4("w8888", 7'h00, 7'h00, 7'h00, 7'h00, 1'b0);
        chk("w8888_value", 32'(word), 32'h8888);

        // backpressure in HOLD with seg_valid held high
        for (int i = 0; i < 5; i++) cyc("hold", 1'b1, 7'h79, 1'b0);
        chk("hold_word", 32'(word), 32'h8888);
        cyc("hold_release", 1'b1, 7'h79, 1'b1);
        chk("hold_ready_back", 32'(seg_ready), 32'h1);
        cyc("after_hold", 1'b0, 7'h7F, 1'b0);

        // word_ready outside HOLD is ignored
        cyc("idle_wr", 1'b1, 7'h24, 1'b1);
        cyc("idle_wr", 1'b0, 7'h7F, 1'b1);

        // async reset mid-collection, then FEDC
        pulse_reset("rst_mid");
        send4("wFEDC", 7'h0E, 7'h06, 7'h21, 7'h46, 1'b0);
        chk("wFEDC_value", 32'(word), 32'hFEDC);
        pulse_reset("rst_hold");

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) pat = 7'($urandom);
            else                           pat = tbl[$urandom_range(0, 15)];
            cyc("rand", $urandom_range(0, 3) != 0, pat, $urandom_range(0, 2) != 0);
        end
        cyc("rand_flush", 1'b0, 7'h7F, 1'b1);
        cyc("rand_flush", 1'b0, 7'h7F, 1'b1);

        // error counter saturation
        pulse_reset("rst_sat");
        for (int i = 0; i < 260; i++) cyc("sat", 1'b1, 7'h7F, 1'b0);
        chk("sat_cnt", 32'(err_cnt), 32'd255);
        cyc("sat_end", 1'b0, 7'h7F, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
